// File: rtl/rv32i_de_pipe.sv
// RV32I/RV32E decode+execute pipe: D/E and E/M slices, internal
// regfile, M/W forwarding, load-use interlock and flush.
module rv32i_de_pipe #(
  parameter int DPW  = 32,
  parameter int NREG = 32,
  parameter int ADW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instrD,
  input  logic           validD,
  input  logic           flushE,
  input  logic           wb_en,
  input  logic [ADW-1:0] wb_addr,
  input  logic [DPW-1:0] wb_data,
  output logic           stallD,
  output logic           illegalD,
  output logic           validM,
  output logic           regwriteM,
  output logic           resultsrcM,
  output logic           memwriteM,
  output logic [DPW-1:0] aluresultM,
  output logic [DPW-1:0] rd2M,
  output logic [ADW-1:0] rdM
);

  typedef enum logic [3:0] {
    A_ADD,
    A_SUB,
    A_SLL,
    A_SLT,
    A_XOR,
    A_SRL,
    A_SRA,
    A_OR,
    A_AND
  } alu_e;

  typedef struct packed {
    logic           valid;
    logic           regwrite;
    logic           resultsrc;
    logic           memwrite;
    logic           alusrc;
    alu_e           op;
    logic [ADW-1:0] rs1;
    logic [ADW-1:0] rs2;
    logic [ADW-1:0] rd;
    logic [DPW-1:0] rd1;
    logic [DPW-1:0] rd2;
    logic [DPW-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic           valid;
    logic           regwrite;
    logic           resultsrc;
    logic           memwrite;
    logic [DPW-1:0] alu;
    logic [DPW-1:0] rd2;
    logic [ADW-1:0] rd;
  } ex_mem_t;

  id_ex_t  de_q;
  id_ex_t  de_d;
  ex_mem_t em_q;
  ex_mem_t em_d;

  logic [DPW-1:0] rf [NREG];

  // ---------------- decode ----------------
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rs1f;
  logic [4:0] rs2f;
  logic [4:0] rdf;

  assign opc  = instrD[6:0];
  assign rdf  = instrD[11:7];
  assign f3   = instrD[14:12];
  assign rs1f = instrD[19:15];
  assign rs2f = instrD[24:20];
  assign f7   = instrD[31:25];

  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;

  assign is_r  = opc == 7'b0110011;
  assign is_i  = opc == 7'b0010011;
  assign is_ld = (opc == 7'b0000011)
              && (f3 == 3'b010);
  assign is_st = (opc == 7'b0100011)
              && (f3 == 3'b010);

  logic use1;
  logic use2;
  logic userd;

  assign use1  = is_r | is_i | is_ld | is_st;
  assign use2  = is_r | is_st;
  assign userd = is_r | is_i | is_ld;

  logic r1_in;
  logic r2_in;
  logic rd_in;

  assign r1_in = {27'd0, rs1f} < 32'(NREG);
  assign r2_in = {27'd0, rs2f} < 32'(NREG);
  assign rd_in = {27'd0, rdf} < 32'(NREG);

  logic [ADW-1:0] rs1a;
  logic [ADW-1:0] rs2a;
  logic [ADW-1:0] rda;

  assign rs1a = rs1f[ADW-1:0];
  assign rs2a = rs2f[ADW-1:0];
  assign rda  = rdf[ADW-1:0];

  alu_e op_d;
  logic op_ok;
  logic f7z;
  logic f7s;

  assign f7z = f7 == 7'h00;
  assign f7s = f7 == 7'h20;

  always_comb begin
    op_d  = A_ADD;
    op_ok = 1'b0;
    unique case (1'b1)
      is_ld, is_st: op_ok = 1'b1;
      is_r, is_i: begin
        unique case (f3)
          3'b000: begin
            op_d  = (is_r && f7s) ? A_SUB : A_ADD;
            op_ok = is_i || f7z || f7s;
          end
          3'b001: begin
            op_d  = A_SLL;
            op_ok = f7z;
          end
          3'b010: begin
            op_d  = A_SLT;
            op_ok = is_i || f7z;
          end
          3'b011: op_ok = 1'b0;
          3'b100: begin
            op_d  = A_XOR;
            op_ok = is_i || f7z;
          end
          3'b101: begin
            op_d  = f7s ? A_SRA : A_SRL;
            op_ok = f7z || f7s;
          end
          3'b110: begin
            op_d  = A_OR;
            op_ok = is_i || f7z;
          end
          3'b111: begin
            op_d  = A_AND;
            op_ok = is_i || f7z;
          end
        endcase
      end
      default: op_ok = 1'b0;
    endcase
  end

  logic legal;

  assign legal = op_ok
              && (!use1 || r1_in)
              && (!use2 || r2_in)
              && (!userd || rd_in);

  assign illegalD = validD && !legal;

  // A load in E can only feed D through memory, so hold D one cycle.
  logic load_e;

  assign load_e = de_q.valid
               && de_q.resultsrc
               && (de_q.rd != '0);

  assign stallD = validD && load_e
               && ((use1 && r1_in && de_q.rd == rs1a)
                || (use2 && r2_in && de_q.rd == rs2a));

  logic [DPW-1:0] rd1_d;
  logic [DPW-1:0] rd2_d;

  assign rd1_d = (rs1a == '0) ? '0
               : (wb_en && wb_addr == rs1a) ? wb_data
               : rf[rs1a];
  assign rd2_d = (rs2a == '0) ? '0
               : (wb_en && wb_addr == rs2a) ? wb_data
               : rf[rs2a];

  logic [DPW-1:0] imm_i;
  logic [DPW-1:0] imm_s;

  assign imm_i = {{(DPW-12){instrD[31]}},
                  instrD[31:20]};
  assign imm_s = {{(DPW-12){instrD[31]}},
                  instrD[31:25], instrD[11:7]};

  always_comb begin
    de_d = '0;
    if (validD && legal && !stallD && !flushE) begin
      de_d.valid     = 1'b1;
      de_d.regwrite  = userd;
      de_d.resultsrc = is_ld;
      de_d.memwrite  = is_st;
      de_d.alusrc    = !is_r;
      de_d.op        = op_d;
      de_d.rs1       = rs1a;
      de_d.rs2       = use2 ? rs2a : '0;
      de_d.rd        = userd ? rda : '0;
      de_d.rd1       = rd1_d;
      de_d.rd2       = rd2_d;
      de_d.imm       = is_st ? imm_s : imm_i;
    end
  end

  // ---------------- execute ----------------
  logic m_fw;

  assign m_fw = em_q.valid
             && em_q.regwrite
             && !em_q.resultsrc;

  logic [DPW-1:0] src_a;
  logic [DPW-1:0] fw_b;
  logic [DPW-1:0] src_b;

  assign src_a = (m_fw && de_q.rs1 != '0
                  && em_q.rd == de_q.rs1) ? em_q.alu
               : (wb_en && de_q.rs1 != '0
                  && wb_addr == de_q.rs1) ? wb_data
               : de_q.rd1;

  assign fw_b = (m_fw && de_q.rs2 != '0
                 && em_q.rd == de_q.rs2) ? em_q.alu
              : (wb_en && de_q.rs2 != '0
                 && wb_addr == de_q.rs2) ? wb_data
              : de_q.rd2;

  assign src_b = de_q.alusrc ? de_q.imm : fw_b;

  logic [4:0]     shamt;
  logic [DPW-1:0] alu_y;
  logic           lt;

  assign shamt = src_b[4:0];
  assign lt    = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_y = '0;
    unique case (de_q.op)
      A_ADD: alu_y = src_a + src_b;
      A_SUB: alu_y = src_a - src_b;
      A_SLL: alu_y = src_a << shamt;
      A_SLT: alu_y = {{(DPW-1){1'b0}}, lt};
      A_XOR: alu_y = src_a ^ src_b;
      A_SRL: alu_y = src_a >> shamt;
      A_SRA: alu_y = $unsigned(
               $signed(src_a) >>> shamt);
      A_OR:  alu_y = src_a | src_b;
      A_AND: alu_y = src_a & src_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    em_d = '0;
    if (de_q.valid) begin
      em_d.valid     = 1'b1;
      em_d.regwrite  = de_q.regwrite;
      em_d.resultsrc = de_q.resultsrc;
      em_d.memwrite  = de_q.memwrite;
      em_d.alu       = alu_y;
      em_d.rd2       = fw_b;
      em_d.rd        = de_q.rd;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= '0;
      em_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      de_q <= de_d;
      em_q <= em_d;
      if (wb_en && wb_addr != '0) begin
        rf[wb_addr] <= wb_data;
      end
    end
  end

  assign validM     = em_q.valid;
  assign regwriteM  = em_q.regwrite;
  assign resultsrcM = em_q.resultsrc;
  assign memwriteM  = em_q.memwrite;
  assign aluresultM = em_q.alu;
  assign rd2M       = em_q.rd2;
  assign rdM        = em_q.rd;

endmodule
